stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Control FSM and time-base for the lab stopwatch. Consumes single-cycle button pulses (start/stop, lap/reset) from the existing pulse generators.
- Sequences a prescaled BCD mm:ss counter and freezes the display for lap readout.
- Output feeds the 7-segment scan driver directly.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per counted second (must be >= 2)
- PRE_W, 27, prescaler width, >= clog2(TICK_DIV)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- start_pulse  in  1  one-cycle pulse, start/stop button
- lap_pulse  in  1  one-cycle pulse, lap/reset button
- disp_min_t  out  4  displayed minutes tens, BCD 0-5
- disp_min_u  out  4  displayed minutes units, BCD 0-9
- disp_sec_t  out  4  displayed seconds tens, BCD 0-5
- disp_sec_u  out  4  displayed seconds units, BCD 0-9
- running  out  1  high in RUN or LAP
- state_o  out  2  current state encoding, for LEDs/debug

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n sampled on posedge clk).
- Reset values:
  - state = IDLE (2'd0).
  - Live count, snapshot and prescaler = 0.
  - All disp_* = 0, running = 0, state_o = 0.
- States: IDLE=0, RUN=1, PAUSE=2, LAP=3. All transitions take effect on the posedge where the pulse is sampled high.
  - IDLE: start -> RUN; lap ignored.
  - RUN: start -> PAUSE; lap -> LAP, and snapshot <= live count as present in that cycle (pre-increment).
  - LAP: lap -> RUN (display releases to live); start -> PAUSE (display shows live count).
  - PAUSE: start -> RUN; lap -> IDLE, clearing live count and prescaler to 0.
- Simultaneous start_pulse and lap_pulse: start wins, lap is dropped.
- Pulses wider than one cycle are treated as one event per high cycle. The caller guarantees single-cycle pulses.
- Prescaler:
  - Counts only in RUN or LAP. Holds its value in PAUSE. Held at 0 in IDLE.
  - When it equals TICK_DIV-1 in a counting state: it wraps to 0 and the live count increments at the same edge.
  - Once RUN is entered from IDLE, the first increment occurs exactly TICK_DIV edges later.
- Live count increment (BCD ripple):
  - sec_u 9 -> 0 with carry; sec_t 5 -> 0 with carry; min_u 9 -> 0 with carry; min_t 5 -> 0.
  - 59:59 + 1 = 00:00. Wrap is silent; no overflow flag.
- Tick and transition on the same edge: a tick in RUN coinciding with start (-> PAUSE) still increments. A tick coinciding with RUN->LAP increments the live count, while the snapshot takes the pre-increment value.
- Display: disp_* = snapshot when state == LAP, else live count. This is a combinational mux of registers; no extra latency beyond the register update.
- running = (state == RUN) || (state == LAP).
- state_o = state register.
- Reset asserted mid-run: the next posedge forces all reset values. Any pulse coincident with reset is ignored.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum/localparams (IDLE, RUN, PAUSE, LAP; 2 bits);
  - BCD limit constants (SEC_T_MAX = 5, UNIT_MAX = 9, MIN_T_MAX = 5).
- One sub-module, bcd_mmss_counter: sync active-low reset, plus clr, inc and four BCD outputs, containing the ripple/wrap logic.
- Prescaler, FSM, snapshot register and display mux stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4):
- Reset, then start pulse, run 12 cycles -> running=1, state_o=1, display 00:03. Increments occur on edges 4, 8 and 12 after the start edge.
- Start at 00:02 with prescaler=2, pause 20 cycles, start again -> count frozen at 00:02 during PAUSE. The next increment comes 2 cycles after resume.
- In RUN at 00:05, lap pulse, run 8 cycles -> display stays 00:05, state_o=3, live count reaches 00:07. Second lap pulse -> display shows 00:07 the next cycle.
- Preload to 59:58 via run, 8 cycles -> display 59:59 then 00:00, no glitch on any digit.
- In PAUSE: start and lap in the same cycle -> state RUN, count not cleared. Then start, then lap in PAUSE -> IDLE, display 00:00, running=0.
- rst_n low for 1 cycle while in LAP at 01:23 -> next cycle: all outputs 0, state IDLE. A start pulse coincident with reset has no effect.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states and BCD digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] UNIT_MAX  = 4'd9;
  localparam logic [3:0] MIN_T_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } mmss_t;

endpackage

// File: rtl/bcd_mmss_counter.sv
// BCD mm:ss counter with synchronous clear and a one-second increment strobe.
// 59:59 rolls over silently to 00:00.
module bcd_mmss_counter
  import stopwatch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_u,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_u
);

  logic [3:0] r_min_t, r_min_u, r_sec_t, r_sec_u;
  logic [3:0] w_min_t, w_min_u, w_sec_t, w_sec_u;

  // Next-count logic: clear wins over increment; increment ripples carries upward.
  always_comb begin
    w_min_t = r_min_t;
    w_min_u = r_min_u;
    w_sec_t = r_sec_t;
    w_sec_u = r_sec_u;
    if (i_clr) begin
      w_min_t = 4'd0;
      w_min_u = 4'd0;
      w_sec_t = 4'd0;
      w_sec_u = 4'd0;
    end else if (i_inc) begin
      if (r_sec_u == UNIT_MAX) begin
        w_sec_u = 4'd0;
        if (r_sec_t == SEC_T_MAX) begin
          w_sec_t = 4'd0;
          if (r_min_u == UNIT_MAX) begin
            w_min_u = 4'd0;
            if (r_min_t == MIN_T_MAX) begin
              w_min_t = 4'd0;
            end else begin
              w_min_t = r_min_t + 4'd1;
            end
          end else begin
            w_min_u = r_min_u + 4'd1;
          end
        end else begin
          w_sec_t = r_sec_t + 4'd1;
        end
      end else begin
        w_sec_u = r_sec_u + 4'd1;
      end
    end else begin
      w_sec_u = r_sec_u;
    end
  end

  // Digit registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_min_t <= 4'd0;
      r_min_u <= 4'd0;
      r_sec_t <= 4'd0;
      r_sec_u <= 4'd0;
    end else begin
      r_min_t <= w_min_t;
      r_min_u <= w_min_u;
      r_sec_t <= w_sec_t;
      r_sec_u <= w_sec_u;
    end
  end

  assign o_min_t = r_min_t;
  assign o_min_u = r_min_u;
  assign o_sec_t = r_sec_t;
  assign o_sec_u = r_sec_u;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop and lap/reset FSM, one-second prescaler,
// lap snapshot register and display mux feeding the 7-segment scanner.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start_pulse,
  input  logic       i_lap_pulse,
  output logic [3:0] o_disp_min_t,
  output logic [3:0] o_disp_min_u,
  output logic [3:0] o_disp_sec_t,
  output logic [3:0] o_disp_sec_u,
  output logic       o_running,
  output logic [1:0] o_state
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_next;
  mmss_t            r_snap;
  mmss_t            w_live;
  mmss_t            w_disp;
  logic             w_start;
  logic             w_lap;
  logic             w_counting;
  logic             w_tick;
  logic             w_take_snap;
  logic             w_clr;

  // Start has priority: a lap pulse in the same cycle is dropped.
  assign w_start    = i_start_pulse;
  assign w_lap      = i_lap_pulse & ~i_start_pulse;
  assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick     = w_counting && (r_pre == PRE_LAST);

  // FSM next state plus the snapshot-capture and count-clear strobes.
  always_comb begin
    w_state_next = r_state;
    w_take_snap  = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_start) begin
          w_state_next = ST_PAUSE;
        end else if (w_lap) begin
          w_state_next = ST_LAP;
          w_take_snap  = 1'b1;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_LAP: begin
        if (w_start) begin
          w_state_next = ST_PAUSE;
        end else if (w_lap) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (w_start) begin
          w_state_next = ST_RUN;
        end else if (w_lap) begin
          w_state_next = ST_IDLE;
          w_clr        = 1'b1;
        end else begin
          w_state_next = ST_PAUSE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Prescaler next value: zero in IDLE or on clear, counts in RUN/LAP, holds in PAUSE.
  always_comb begin
    w_pre_next = r_pre;
    if (w_clr || (r_state == ST_IDLE)) begin
      w_pre_next = '0;
    end else if (w_tick) begin
      w_pre_next = '0;
    end else if (w_counting) begin
      w_pre_next = r_pre + PRE_W'(1);
    end else begin
      w_pre_next = r_pre;
    end
  end

  // State, prescaler and lap snapshot registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pre   <= w_pre_next;
      if (w_take_snap) begin
        r_snap <= w_live;
      end
    end
  end

  bcd_mmss_counter u_count (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_tick),
    .o_min_t (w_live.min_t),
    .o_min_u (w_live.min_u),
    .o_sec_t (w_live.sec_t),
    .o_sec_u (w_live.sec_u)
  );

  // Display shows the frozen lap snapshot in LAP, otherwise the live count.
  always_comb begin
    if (r_state == ST_LAP) begin
      w_disp = r_snap;
    end else begin
      w_disp = w_live;
    end
  end

  assign o_disp_min_t = w_disp.min_t;
  assign o_disp_min_u = w_disp.min_u;
  assign o_disp_sec_t = w_disp.sec_t;
  assign o_disp_sec_u = w_disp.sec_u;
  assign o_running    = w_counting;
  assign o_state      = r_state;

endmodule
